mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// +----------------------------------------------------------------------+
// | mem_responder_if : request/response bus between processor and memory |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              Req;
  logic              WrEn;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] RdData;
  logic              Ack;
  logic              Busy;
  logic              Err;

  modport master (
    output Req, WrEn, Addr, WrData,
    input  RdData, Ack, Busy, Err
  );

  modport slave (
    input  Req, WrEn, Addr, WrData,
    output RdData, Ack, Busy, Err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// +----------------------------------------------------------------------+
// | mem_responder : single-port word memory with wait-stated handshake   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  wire logic       Clock,
  input  wire logic       Resetn,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] C_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] C_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              go_resp;
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_wr;
  logic [DATA_W-1:0] eff_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;

  // With zero wait states RESP is entered on the accepting edge itself,
  // so the access must be taken straight from the bus in that case.
  always_comb begin
    eff_addr  = addr_q;
    eff_wr    = wr_q;
    eff_wdata = wdata_q;
    if (state_q == IDLE) begin
      eff_addr  = bus.Addr;
      eff_wr    = bus.WrEn;
      eff_wdata = bus.WrData;
    end
    in_range = ({1'b0, eff_addr} < C_DEPTH_EXT);
    idx      = eff_addr[IDX_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    go_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          addr_d  = bus.Addr;
          wr_d    = bus.WrEn;
          wdata_d = bus.WrData;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = C_WAIT_INIT;
          end else begin
            state_d = RESP;
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_resp) begin
      err_d = ~in_range;
      if (!eff_wr) begin
        rd_data_d = in_range ? mem[idx] : '0;
      end
    end

    ack_d  = go_resp;
    busy_d = (state_d != IDLE);
  end

  assign mem_we = go_resp & eff_wr & in_range;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[idx] <= eff_wdata;
    end
  end

  assign bus.RdData = rd_data_q;
  assign bus.Ack    = ack_q;
  assign bus.Busy   = busy_q;
  assign bus.Err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// +----------------------------------------------------------------------+
// | tb_mem_responder : directed bench for mem_responder, WS = 0 / 1 / 3   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_responder;

  typedef struct {
    logic        ack;
    logic        busy;
    logic        err;
    logic [15:0] rd;
  } outs_t;

  logic Clock = 1'b0;
  logic resetn0;
  logic resetn1;
  logic resetn3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus_ws0 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus_ws1 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus_ws3 ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .Clock(Clock), .Resetn(resetn0), .bus(bus_ws0.slave));
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .Clock(Clock), .Resetn(resetn1), .bus(bus_ws1.slave));
  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .Clock(Clock), .Resetn(resetn3), .bus(bus_ws3.slave));

  task automatic drive(input int which, input logic req, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    case (which)
      0: begin bus_ws0.Req = req; bus_ws0.WrEn = wr; bus_ws0.Addr = a; bus_ws0.WrData = d; end
      1: begin bus_ws1.Req = req; bus_ws1.WrEn = wr; bus_ws1.Addr = a; bus_ws1.WrData = d; end
      default: begin bus_ws3.Req = req; bus_ws3.WrEn = wr; bus_ws3.Addr = a; bus_ws3.WrData = d; end
    endcase
  endtask

  function automatic outs_t get_outs(input int which);
    outs_t o;
    case (which)
      0: begin o.ack = bus_ws0.Ack; o.busy = bus_ws0.Busy; o.err = bus_ws0.Err; o.rd = bus_ws0.RdData; end
      1: begin o.ack = bus_ws1.Ack; o.busy = bus_ws1.Busy; o.err = bus_ws1.Err; o.rd = bus_ws1.RdData; end
      default: begin o.ack = bus_ws3.Ack; o.busy = bus_ws3.Busy; o.err = bus_ws3.Err; o.rd = bus_ws3.RdData; end
    endcase
    return o;
  endfunction

  // One access: lat is the cycle (1 = right after the accepting edge) in
  // which Ack is seen, 0 if it never came. Inputs are scrambled while busy.
  task automatic access(input int which, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic busy_acc,
                        output outs_t at_ack, output outs_t after_ack);
    outs_t o;
    @(negedge Clock);
    drive(which, 1'b1, wr, a, d);
    @(posedge Clock); #1;
    busy_acc = get_outs(which).busy;
    drive(which, 1'b0, ~wr, a ^ 16'h0002, ~d);
    lat    = 0;
    at_ack = get_outs(which);
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) begin
        @(posedge Clock); #1;
      end
      o = get_outs(which);
      if (o.ack) begin
        lat    = i;
        at_ack = o;
        break;
      end
    end
    @(posedge Clock); #1;
    after_ack = get_outs(which);
  endtask

  task automatic test_reset;
    outs_t o;
    resetn0 = 1'b0; resetn1 = 1'b0; resetn3 = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(3, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge Clock);
    #1;
    for (int w = 0; w < 4; w++) begin
      if (w == 2) continue;
      o = get_outs(w);
      n_checks++;
      if ({o.ack, o.busy, o.err, o.rd} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_outputs ws=%0d: ack=%b busy=%b err=%b rd=%h, required all zero",
                 w, o.ack, o.busy, o.err, o.rd);
      end
    end
    @(negedge Clock);
    resetn0 = 1'b1; resetn1 = 1'b1; resetn3 = 1'b1;
  endtask

  task automatic test_store_load;
    int lat; logic ba; outs_t a, n;
    access(1, 1'b1, 16'd3, 16'h0004, lat, ba, a, n);
    n_checks++;
    if (ba !== 1'b1) begin n_fail++; $display("FAIL store3_busy: busy=%b, required 1", ba); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL store3_latency: got %0d, required 2", lat); end
    n_checks++;
    if (a.err !== 1'b0) begin n_fail++; $display("FAIL store3_err: got %b, required 0", a.err); end
    n_checks++;
    if ({n.ack, n.busy} !== 2'b00) begin
      n_fail++; $display("FAIL store3_ack_width: ack=%b busy=%b after Ack, required 0 0", n.ack, n.busy);
    end
    access(1, 1'b0, 16'd3, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL load3_latency: got %0d, required 2", lat); end
    n_checks++;
    if (a.rd !== 16'h0004 || a.err !== 1'b0) begin
      n_fail++; $display("FAIL load3_data: rd=%h err=%b, required 0004 0", a.rd, a.err);
    end
    n_checks++;
    if (n.ack !== 1'b0) begin n_fail++; $display("FAIL load3_ack_width: ack=%b, required 0", n.ack); end
  endtask

  task automatic test_rd_hold;
    int lat; logic ba; outs_t a, n;
    access(1, 1'b1, 16'd9, 16'h1234, lat, ba, a, n);
    n_checks++;
    if (a.rd !== 16'h0004 || n.rd !== 16'h0004) begin
      n_fail++; $display("FAIL store_keeps_rd: at_ack=%h after=%h, required 0004", a.rd, n.rd);
    end
    access(1, 1'b0, 16'd9, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (a.rd !== 16'h1234) begin n_fail++; $display("FAIL load9_data: got %h, required 1234", a.rd); end
  endtask

  task automatic test_out_of_range;
    int lat; logic ba; outs_t a, n;
    access(1, 1'b1, 16'h0000, 16'h5A5A, lat, ba, a, n);
    access(1, 1'b0, 16'h0100, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (lat !== 2 || a.err !== 1'b1 || a.rd !== 16'h0000) begin
      n_fail++; $display("FAIL oor_load: lat=%0d err=%b rd=%h, required 2 1 0000", lat, a.err, a.rd);
    end
    n_checks++;
    if (n.err !== 1'b0) begin n_fail++; $display("FAIL oor_err_width: err=%b after Ack, required 0", n.err); end
    access(1, 1'b1, 16'h0100, 16'h7777, lat, ba, a, n);
    n_checks++;
    if (a.err !== 1'b1) begin n_fail++; $display("FAIL oor_store_err: got %b, required 1", a.err); end
    access(1, 1'b0, 16'h0000, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (a.rd !== 16'h5A5A || a.err !== 1'b0) begin
      n_fail++; $display("FAIL addr0_unchanged: rd=%h err=%b, required 5A5A 0", a.rd, a.err);
    end
  endtask

  task automatic test_back_to_back;
    int acc_cyc[4];
    int n_acc = 0;
    logic prev_busy = 1'b0;
    logic [15:0] nxt_a[4] = '{16'd2, 16'd1, 16'd2, 16'd1};
    logic [15:0] nxt_d[4] = '{16'h2222, 16'h3333, 16'h4444, 16'hBAD0};
    int lat; logic ba; outs_t a, n, o;
    @(negedge Clock);
    drive(1, 1'b1, 1'b1, 16'd1, 16'h1111);
    for (int c = 0; c < 40 && n_acc < 4; c++) begin
      @(posedge Clock); #1;
      o = get_outs(1);
      if (o.busy && !prev_busy) begin
        acc_cyc[n_acc] = c;
        // Next request goes on the bus at once; the active one must ignore it.
        @(negedge Clock);
        drive(1, n_acc < 3, 1'b1, nxt_a[n_acc], nxt_d[n_acc]);
        n_acc++;
      end
      prev_busy = o.busy;
    end
    n_checks++;
    if (n_acc !== 4) begin
      n_fail++; $display("FAIL b2b_accept_count: got %0d, required 4", n_acc);
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin
          n_fail++; $display("FAIL b2b_spacing_%0d: got %0d cycles, required 3", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    repeat (4) @(posedge Clock);
    access(1, 1'b0, 16'd1, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (a.rd !== 16'h3333) begin n_fail++; $display("FAIL b2b_addr1: got %h, required 3333", a.rd); end
    access(1, 1'b0, 16'd2, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (a.rd !== 16'h4444) begin n_fail++; $display("FAIL b2b_addr2: got %h, required 4444", a.rd); end
  endtask

  task automatic test_reset_in_wait;
    int lat; logic ba; outs_t a, n, o;
    logic saw_ack = 1'b0;
    access(3, 1'b1, 16'd5, 16'h1357, lat, ba, a, n);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency: got %0d, required 4", lat); end
    access(3, 1'b0, 16'd5, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (a.rd !== 16'h1357) begin n_fail++; $display("FAIL ws3_load5: got %h, required 1357", a.rd); end
    @(negedge Clock);
    drive(3, 1'b1, 1'b1, 16'd5, 16'hBEEF);
    @(posedge Clock); #1;
    drive(3, 1'b0, 1'b0, 16'd0, 16'h0);
    @(posedge Clock);
    @(negedge Clock);
    resetn3 = 1'b0;
    #1;
    o = get_outs(3);
    n_checks++;
    if ({o.ack, o.busy, o.err, o.rd} !== 19'd0) begin
      n_fail++; $display("FAIL reset_in_wait_outputs: ack=%b busy=%b err=%b rd=%h, required all zero",
                         o.ack, o.busy, o.err, o.rd);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge Clock); #1;
      if (get_outs(3).ack) saw_ack = 1'b1;
      if (c == 2) #1 resetn3 = 1'b1;
    end
    n_checks++;
    if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_wait_ack: saw Ack=1, required none"); end
    repeat (2) @(posedge Clock);
    @(posedge Clock); #1;
    resetn3 = 1'b0;
    @(posedge Clock); #2;
    resetn3 = 1'b1;
    access(3, 1'b0, 16'd5, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (ba !== 1'b1) begin n_fail++; $display("FAIL first_req_after_reset: busy=%b, required 1", ba); end
    n_checks++;
    if (a.rd !== 16'h1357 || lat !== 4) begin
      n_fail++; $display("FAIL aborted_store: rd=%h lat=%0d, required 1357 4", a.rd, lat);
    end
  endtask

  task automatic test_zero_wait;
    int lat; logic ba; outs_t a, n;
    access(0, 1'b1, 16'd7, 16'hC0DE, lat, ba, a, n);
    n_checks++;
    if (lat !== 1 || ba !== 1'b1) begin
      n_fail++; $display("FAIL ws0_store: lat=%0d busy=%b, required 1 1", lat, ba);
    end
    n_checks++;
    if (n.ack !== 1'b0) begin n_fail++; $display("FAIL ws0_ack_width: ack=%b, required 0", n.ack); end
    access(0, 1'b0, 16'd7, 16'h0000, lat, ba, a, n);
    n_checks++;
    if (lat !== 1 || a.rd !== 16'hC0DE || a.err !== 1'b0) begin
      n_fail++; $display("FAIL ws0_load: lat=%0d rd=%h err=%b, required 1 C0DE 0", lat, a.rd, a.err);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_rd_hold();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_wait();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
